// File: rtl/unified_ram.sv
// unified_ram: single storage array that serves a combinational instruction
// fetch port and a registered, ready/valid data port. A sequential clear
// engine refills every word with INIT_VAL.
//
// Optional feature macro: UNIFIED_RAM_WRITE_FIRST_EN
//   defined   : a data-port read that collides with a write landing on the
//               same edge returns the new data (write-first)
//   undefined : read-first; data_read_data is taken from pre-edge contents
//
// Ports:
//   i_clk            clock, all state changes on rising edge
//   i_rst            synchronous active-high reset of control state only
//   i_pc_address     fetch address
//   o_pc_read_data   combinational fetch data
//   i_data_req       data-port request (accepted when o_data_ready=1)
//   i_data_we        1 = write, 0 = read
//   i_data_address   data-port address
//   i_write_data     write data
//   o_data_ready     high in IDLE, low while clearing
//   o_data_valid     one-cycle pulse with o_data_read_data
//   o_data_read_data registered read data, held until the next read
//   i_clear_req      start a full-array fill with INIT_VAL
//   o_clear_done     one-cycle pulse when the fill completes
module unified_ram #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 7,
   parameter int                DEPTH     = 128,
   parameter logic [DATA_W-1:0] INIT_VAL  = '1,
   parameter                    INIT_FILE = ""
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_pc_address,
   output logic [DATA_W-1:0] o_pc_read_data,
   input  logic              i_data_req,
   input  logic              i_data_we,
   input  logic [ADDR_W-1:0] i_data_address,
   input  logic [DATA_W-1:0] i_write_data,
   output logic              o_data_ready,
   output logic              o_data_valid,
   output logic [DATA_W-1:0] o_data_read_data,
   input  logic              i_clear_req,
   output logic              o_clear_done
);

   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_valid;
   logic              r_clear_done;
   logic [DATA_W-1:0] r_rd_data;

   logic              w_ready;
   logic              w_clr_we;
   logic              w_cnt_last;
   logic              w_accept;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_da_in;
   logic              w_pc_in;
   logic [DATA_W-1:0] w_rd_word;

   // Array power-up image: every word starts at the fill value.
   initial begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] = INIT_VAL;
   end

   assign w_pc_in = {1'b0, i_pc_address}   < LP_DEPTH;
   assign w_da_in = {1'b0, i_data_address} < LP_DEPTH;

   // Requests seen while rst is high are not accepted, so reset leaves
   // data_valid low and touches no word.
   assign w_accept   = i_data_req && w_ready && !i_rst;
   assign w_rd_acc   = w_accept && !i_data_we;
   assign w_wr_acc   = w_accept &&  i_data_we;
   assign w_cnt_last = (r_cnt == LP_LAST);

   always_comb begin
      w_next   = r_state;
      w_ready  = 1'b0;
      w_clr_we = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (i_clear_req) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            w_clr_we = !i_rst;
            if (w_cnt_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_valid      <= 1'b0;
         r_clear_done <= 1'b0;
         r_rd_data    <= '0;
      end else begin
         r_state      <= w_next;
         r_valid      <= w_rd_acc;
         r_clear_done <= (r_state == S_CLEAR) && w_cnt_last;
         // Counter only runs in CLEAR and wraps to 0 after the last word,
         // so it is already zero on the next entry.
         if (r_state == S_CLEAR && !w_cnt_last) r_cnt <= r_cnt + 1'b1;
         else                                   r_cnt <= '0;
         if (w_rd_acc) r_rd_data <= w_rd_word;
      end
   end

   // Clear writes and data writes never coincide: data is only accepted in IDLE.
   always_ff @(posedge i_clk) begin
      if (w_clr_we)
         r_mem[r_cnt] <= INIT_VAL;
      else if (w_wr_acc && w_da_in)
         r_mem[i_data_address] <= i_write_data;
   end

   always_comb begin
      w_rd_word = w_da_in ? r_mem[i_data_address] : INIT_VAL;
`ifdef UNIFIED_RAM_WRITE_FIRST_EN
      // Forward a same-edge clear write into the read result.
      if (w_clr_we && r_cnt == i_data_address) w_rd_word = INIT_VAL;
`else
      // Read-first: pre-edge array contents are captured unmodified.
`endif
   end

   assign o_pc_read_data   = w_pc_in ? r_mem[i_pc_address] : INIT_VAL;
   assign o_data_ready     = w_ready;
   assign o_data_valid     = r_valid;
   assign o_data_read_data = r_rd_data;
   assign o_clear_done     = r_clear_done;

endmodule

// File: tb/tb_unified_ram.sv
module tb_unified_ram;

   logic        clk = 1'b0;
   logic        rst;
   // default instance (DEPTH=128)
   logic [6:0]  a_pc, a_addr;
   logic [15:0] a_pc_rd, a_wd, a_rd;
   logic        a_req, a_we, a_ready, a_valid, a_clr, a_done;
   // reduced-depth instance (DEPTH=100)
   logic [6:0]  b_pc, b_addr;
   logic [15:0] b_pc_rd, b_wd, b_rd;
   logic        b_req, b_we, b_ready, b_valid, b_clr, b_done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [15:0] qa[$];
   logic [15:0] qb[$];

   always #5 clk = ~clk;

   unified_ram dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_pc_address(a_pc), .o_pc_read_data(a_pc_rd),
      .i_data_req(a_req), .i_data_we(a_we), .i_data_address(a_addr),
      .i_write_data(a_wd), .o_data_ready(a_ready), .o_data_valid(a_valid),
      .o_data_read_data(a_rd), .i_clear_req(a_clr), .o_clear_done(a_done)
   );

   unified_ram #(.DEPTH(100)) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_pc_address(b_pc), .o_pc_read_data(b_pc_rd),
      .i_data_req(b_req), .i_data_we(b_we), .i_data_address(b_addr),
      .i_write_data(b_wd), .o_data_ready(b_ready), .o_data_valid(b_valid),
      .o_data_read_data(b_rd), .i_clear_req(b_clr), .o_clear_done(b_done)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample and drain the scoreboards.
   task automatic tick();
      logic [15:0] e;
      @(posedge clk);
      #1;
      if (a_done === 1'b1) done_cnt++;
      if (a_valid === 1'b1) begin
         if (qa.size() == 0) chk("a_unexpected_valid", 16'd1, 16'd0);
         else begin e = qa.pop_front(); chk("a_read_data", a_rd, e); end
      end
      if (b_valid === 1'b1) begin
         if (qb.size() == 0) chk("b_unexpected_valid", 16'd1, 16'd0);
         else begin e = qb.pop_front(); chk("b_read_data", b_rd, e); end
      end
   endtask

   task automatic a_read(input logic [6:0] ad, input logic [15:0] exp);
      a_req = 1'b1; a_we = 1'b0; a_addr = ad; qa.push_back(exp);
      tick();
      a_req = 1'b0;
   endtask

   task automatic a_write(input logic [6:0] ad, input logic [15:0] d);
      a_req = 1'b1; a_we = 1'b1; a_addr = ad; a_wd = d;
      tick();
      a_req = 1'b0; a_we = 1'b0;
   endtask

   task automatic b_read(input logic [6:0] ad, input logic [15:0] exp);
      b_req = 1'b1; b_we = 1'b0; b_addr = ad; qb.push_back(exp);
      tick();
      b_req = 1'b0;
   endtask

   task automatic b_write(input logic [6:0] ad, input logic [15:0] d);
      b_req = 1'b1; b_we = 1'b1; b_addr = ad; b_wd = d;
      tick();
      b_req = 1'b0; b_we = 1'b0;
   endtask

   // Tick until a_ready rises; returns the number of ticks taken.
   task automatic wait_ready(output int n);
      n = 0;
      while (a_ready !== 1'b1 && n < 400) begin tick(); n++; end
      if (n >= 400) chk("ready_timeout", 16'd0, 16'd1);
   endtask

   initial begin
      int n;
      int d0;
      rst = 1'b1;
      a_pc = '0; a_addr = '0; a_wd = '0; a_req = 0; a_we = 0; a_clr = 0;
      b_pc = '0; b_addr = '0; b_wd = '0; b_req = 0; b_we = 0; b_clr = 0;
      tick(); tick();
      chk("rst_ready", {15'd0, a_ready}, 16'd1);
      chk("rst_valid", {15'd0, a_valid}, 16'd0);
      chk("rst_done",  {15'd0, a_done},  16'd0);
      chk("rst_rdata", a_rd, 16'h0000);
      rst = 1'b0;
      tick();

      // power-up contents
      a_read(7'd5, 16'hFFFF);
      a_pc = 7'd5; #1;
      chk("pc_init5", a_pc_rd, 16'hFFFF);

      // write then read, fetch sees it right after the write edge
      a_pc = 7'd29;
      a_write(7'd29, 16'h0016);
      chk("pc_after_write", a_pc_rd, 16'h0016);
      chk("no_valid_on_write", {15'd0, a_valid}, 16'd0);
      a_read(7'd29, 16'h0016);

      // back-to-back reads, one valid per cycle
      a_write(7'd127, 16'h7F7F);
      a_read(7'd127, 16'h7F7F);
      a_read(7'd29, 16'h0016);
      a_read(7'd5, 16'hFFFF);
      chk("held_rdata", a_rd, 16'hFFFF);

      // full clear
      a_write(7'd10, 16'h1234);
      a_write(7'd100, 16'h5555);
      d0 = done_cnt;
      a_clr = 1'b1; tick(); a_clr = 1'b0;
      chk("clear_ready_low", {15'd0, a_ready}, 16'd0);
      wait_ready(n);
      chk("clear_len", 16'(n), 16'd128);
      chk("clear_done_once", 16'(done_cnt - d0), 16'd1);
      a_read(7'd10, 16'hFFFF);
      a_read(7'd100, 16'hFFFF);
      a_pc = 7'd127; #1;
      chk("pc_cleared127", a_pc_rd, 16'hFFFF);

      // reset in the middle of a clear
      a_write(7'd20, 16'h2222);
      a_write(7'd50, 16'h5050);
      a_write(7'd100, 16'h5555);
      d0 = done_cnt;
      a_clr = 1'b1; tick(); a_clr = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_ready", {15'd0, a_ready}, 16'd1);
      for (int i = 0; i < 3; i++) tick();
      chk("midrst_no_done", 16'(done_cnt - d0), 16'd0);
      a_read(7'd20, 16'hFFFF);
      a_read(7'd50, 16'h5050);
      a_read(7'd100, 16'h5555);

      // request held through a clear is taken on the first IDLE edge
      a_clr = 1'b1; tick(); a_clr = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 7'd50;
      wait_ready(n);
      chk("held_req_wait", 16'(n), 16'd128);
      qa.push_back(16'hFFFF);
      tick();
      a_req = 1'b0;
      chk("held_req_valid", {15'd0, a_valid}, 16'd1);

      // reduced depth: out-of-range writes dropped, reads give fill value
      b_write(7'd99, 16'h0099);
      b_write(7'd120, 16'hABCD);
      b_read(7'd120, 16'hFFFF);
      chk("b_oor_valid", {15'd0, b_valid}, 16'd1);
      b_read(7'd99, 16'h0099);
      b_read(7'd20, 16'hFFFF);
      b_pc = 7'd120; #1;
      chk("b_pc_oor", b_pc_rd, 16'hFFFF);
      b_pc = 7'd99; #1;
      chk("b_pc_last", b_pc_rd, 16'h0099);

      tick(); tick();
      chk("a_queue_drained", 16'(qa.size()), 16'd0);
      chk("b_queue_drained", 16'(qb.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
